// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key capture path.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         FRAME_LEN = 11;

    typedef logic [3:0] bcd_t;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == bcd_t'(9)) ? bcd_t'(0) : d + bcd_t'(1);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scancode FIFO with a registered head byte and valid/pop read side.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]    count, count_n;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign rd_next = rd_ptr + AW'(1);

    always_comb begin
        count_n = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            count <= count_n;
            valid <= (count_n != '0);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_next;
            // Head is refreshed either from the incoming byte (queue about to
            // hold only it) or from the next stored entry after a pop.
            if (do_push && (count == '0 || (do_pop && count == CW'(1))))
                head <= push_data;
            else if (do_pop && count > CW'(1))
                head <= mem[rd_next];
        end
    end

endmodule

// File: rtl/ps2_key_capture.sv
// PS/2 frame receiver feeding a scancode FIFO, with make/break tracking
// and a two-digit BCD key-press counter.
module ps2_key_capture
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       overflow,
    output logic       frame_err,
    output logic       key_down,
    output logic [7:0] cur_code,
    output logic [3:0] press_lo,
    output logic [3:0] press_hi,
    input  logic       err_clr
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]           clk_sync, data_sync;
    logic                 sample;
    logic [FRAME_LEN-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic [TW-1:0]        idle_cnt;
    logic                 frame_done;
    logic                 frame_ok, frame_bad;
    logic [7:0]           frame_byte;
    logic                 pop, full;
    logic                 break_pending;

    assign sample     = clk_sync[2] & ~clk_sync[1];
    assign frame_byte = shreg[8:1];
    assign frame_ok   = frame_done & ~shreg[0] & shreg[FRAME_LEN-1] & (^shreg[9:1]);
    assign frame_bad  = frame_done & ~frame_ok;
    assign pop        = rd_valid & rd_ready;

    // Pad inputs idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sample) begin
                shreg    <= {data_sync[1], shreg[FRAME_LEN-1:1]};
                idle_cnt <= TW'(TIMEOUT_CYC - 1);
                if (bit_cnt == 4'(FRAME_LEN - 1)) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != '0) begin
                if (idle_cnt == '0) bit_cnt  <= '0;
                else                idle_cnt <= idle_cnt - TW'(1);
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (frame_ok),
        .push_data (frame_byte),
        .full      (full),
        .pop       (pop),
        .valid     (rd_valid),
        .head      (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (frame_ok && full && !pop) overflow  <= 1'b1;
            if (frame_bad)                frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_pending <= 1'b0;
            key_down      <= 1'b0;
            cur_code      <= '0;
            press_lo      <= '0;
            press_hi      <= '0;
        end else if (frame_ok) begin
            if (frame_byte == PS2_BREAK) begin
                break_pending <= 1'b1;
            end else if (frame_byte != PS2_EXT) begin
                if (break_pending) begin
                    key_down      <= 1'b0;
                    break_pending <= 1'b0;
                end else begin
                    cur_code <= frame_byte;
                    if (!key_down) begin
                        key_down <= 1'b1;
                        press_lo <= bcd_inc(press_lo);
                        if (press_lo == bcd_t'(9)) press_hi <= bcd_inc(press_hi);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_capture.sv
// Directed bench for ps2_key_capture: framing, FIFO, key tracking, BCD count.
module tb_ps2_key_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       rd_valid, overflow, frame_err, key_down;
    logic [7:0] rd_data, cur_code;
    logic [3:0] press_lo, press_hi;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    ps2_key_capture #(.FIFO_DEPTH(8), .TIMEOUT_CYC(4096)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .overflow  (overflow),
        .frame_err (frame_err),
        .key_down  (key_down),
        .cur_code  (cur_code),
        .press_lo  (press_lo),
        .press_hi  (press_hi),
        .err_clr   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk(b, 1'b0, 1'b0), 11);
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_data"}, rd_data, exp);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_key", key_down, 0);
        chk("rst_code", cur_code, 0);
        chk("rst_cnt", {press_hi, press_lo}, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // make 1C, break F0 1C
        send(8'h1C);
        chk("t1_key_make", key_down, 1);
        send(8'hF0);
        chk("t1_key_f0", key_down, 1);
        send(8'h1C);
        chk("t1_key_brk", key_down, 0);
        chk("t1_code", cur_code, 8'h1C);
        chk("t1_cnt", {press_hi, press_lo}, 8'h01);
        pop_chk("t1_q0", 8'h1C);
        pop_chk("t1_q1", 8'hF0);
        pop_chk("t1_q2", 8'h1C);
        chk("t1_empty", rd_valid, 0);

        // typematic: only the first make counts
        for (int i = 0; i < 3; i++) begin
            send(8'h1C);
            chk("t2_key", key_down, 1);
            chk("t2_cnt", {press_hi, press_lo}, 8'h02);
        end
        for (int i = 0; i < 3; i++) pop_chk("t2_q", 8'h1C);
        chk("t2_empty", rd_valid, 0);

        // overflow on the ninth frame
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
        chk("t3_ovf_at8", overflow, 0);
        send(8'h19);
        chk("t3_ovf_at9", overflow, 1);
        chk("t3_code", cur_code, 8'h19);
        for (int i = 0; i < 8; i++) pop_chk("t3_q", 8'h11 + 8'(i));
        chk("t3_empty", rd_valid, 0);
        clear_errs();
        chk("t3_ovf_clr", overflow, 0);

        // bad parity, then bad stop
        send_bits(mk(8'h33, 1'b1, 1'b0), 11);
        repeat (8) @(negedge clk);
        chk("t4_ferr_par", frame_err, 1);
        chk("t4_empty_par", rd_valid, 0);
        chk("t4_code_par", cur_code, 8'h19);
        chk("t4_key_par", key_down, 1);
        clear_errs();
        chk("t4_ferr_clr", frame_err, 0);
        send_bits(mk(8'h2B, 1'b0, 1'b1), 11);
        repeat (8) @(negedge clk);
        chk("t4_ferr_stop", frame_err, 1);
        chk("t4_empty_stop", rd_valid, 0);
        chk("t4_code_stop", cur_code, 8'h19);
        chk("t4_cnt", {press_hi, press_lo}, 8'h02);
        clear_errs();

        // partial frame dropped by timeout
        send_bits(mk(8'h55, 1'b0, 1'b0), 6);
        repeat (4101) @(negedge clk);
        send(8'h2A);
        chk("t5_ferr", frame_err, 0);
        chk("t5_code", cur_code, 8'h2A);
        pop_chk("t5_q", 8'h2A);
        chk("t5_empty", rd_valid, 0);

        // counter wrap through 09->10 and 99->00
        rd_ready = 1'b1;
        send(8'hF0);
        send(8'h2A);
        chk("t6_released", key_down, 0);
        for (int k = 1; k <= 98; k++) begin
            send(8'h16);
            exp_cnt = (2 + k) % 100;
            if (k == 7 || k == 8 || k == 97 || k == 98)
                chk("t6_cnt", {press_hi, press_lo}, {4'(exp_cnt / 10), 4'(exp_cnt % 10)});
            send(8'hF0);
            send(8'h16);
        end
        chk("t6_key_end", key_down, 0);

        // E0 prefix does not disturb a pending break
        send(8'h75);
        chk("t7_cnt", {press_hi, press_lo}, 8'h01);
        send(8'hF0);
        send(8'hE0);
        chk("t7_key_e0", key_down, 1);
        send(8'h75);
        chk("t7_key_brk", key_down, 0);
        chk("t7_code", cur_code, 8'h75);
        repeat (4) @(negedge clk);
        rd_ready = 1'b0;
        chk("t7_empty", rd_valid, 0);

        // asynchronous reset in the middle of a frame
        send_bits(mk(8'h44, 1'b1, 1'b0), 11);
        repeat (8) @(negedge clk);
        send(8'h44);
        chk("t8_pre_valid", rd_valid, 1);
        chk("t8_pre_ferr", frame_err, 1);
        send_bits(mk(8'h66, 1'b0, 1'b0), 5);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_valid", rd_valid, 0);
        chk("t8_data", rd_data, 0);
        chk("t8_ferr", frame_err, 0);
        chk("t8_key", key_down, 0);
        chk("t8_code", cur_code, 0);
        chk("t8_cnt", {press_hi, press_lo}, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h1C);
        chk("t8_post_ferr", frame_err, 0);
        chk("t8_post_cnt", {press_hi, press_lo}, 8'h01);
        pop_chk("t8_post_q", 8'h1C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
